pv_power_sampler: RTL and testbench
===================================

PV_POWER_SAMPLER -- requirements
Module: pv_power_sampler

Interface
REQ-001 SHALL have parameter ADC_DIV, default 4: clk cycles per ADC clock half-period (>=1).
REQ-002 SHALL have parameter AVG_LOG2, default 3: log2 of the number of samples averaged per measurement (0..6).
REQ-003 SHALL have parameter SETTLE_CYC, default 1000: clk cycles waited after start before the first sample (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request one power measurement, sampled in IDLE only.
REQ-007 SHALL have port ad1_in  input  12  PV voltage ADC code, unsigned.
REQ-008 SHALL have port ad2_in  input  12  PV current ADC code, unsigned.
REQ-009 SHALL have port ad1_clk  output  1  voltage ADC conversion clock.
REQ-010 SHALL have port ad2_clk  output  1  current ADC conversion clock, identical to ad1_clk.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  single-cycle pulse when results update.
REQ-013 SHALL have port v_avg  output  12  averaged voltage code.
REQ-014 SHALL have port i_avg  output  12  averaged current code.
REQ-015 SHALL have port power  output  24  v_avg * i_avg, unsigned fitness value.
REQ-016 SHALL have port ovr  output  1  overrange flag for the last measurement.

Function
REQ-017 SHALL implement FSM IDLE -> SETTLE -> SAMPLE -> CALC -> DONE -> IDLE.
REQ-018 SHALL leave IDLE when start=1; start in any other state SHALL be ignored (not queued).
REQ-019 SHALL stay in SETTLE exactly SETTLE_CYC cycles, ADC clocks held low, so the PWM duty settles.
REQ-020 SHALL in SAMPLE toggle ad1_clk/ad2_clk every ADC_DIV cycles, starting low, period 2*ADC_DIV; low outside SAMPLE.
REQ-021 SHALL capture ad1_in and ad2_in on the clk cycle in which the ADC clocks fall high->low, one sample per ADC period.
REQ-022 SHALL accumulate samples in (12+AVG_LOG2)-bit accumulators, cleared on SETTLE entry; no overflow possible.
REQ-023 SHALL enter CALC after 2^AVG_LOG2 samples; SAMPLE lasts exactly 2^AVG_LOG2*2*ADC_DIV cycles.
REQ-024 SHALL in CALC register v_avg = vacc>>AVG_LOG2, i_avg = iacc>>AVG_LOG2 (truncating), power = full 24-bit product of those averages.
REQ-025 SHALL assert done for exactly the one cycle in DONE, return to IDLE next cycle.
REQ-026 SHALL give start-to-done latency SETTLE_CYC + 2^AVG_LOG2*2*ADC_DIV + 2 cycles, counting the start-sampled cycle as 0.
REQ-027 SHALL hold v_avg, i_avg, power, ovr stable between done pulses.
REQ-028 SHALL, if start=1 in the DONE cycle, ignore it; start in the following IDLE cycle SHALL launch normally.

Reset
REQ-029 SHALL on reset, in any state, go to IDLE next cycle; busy=0, done=0, ad1_clk=ad2_clk=0, v_avg=i_avg=0, power=0, ovr=0, accumulators and counters 0.
REQ-030 SHALL discard a partial measurement interrupted by reset; no done pulse for it.

Configuration
REQ-031 SHALL with PV_SAMPLER_OVR_EN defined set ovr=1 in CALC if any sample of the measurement equalled 12'hFFF on either channel, else 0.
REQ-032 SHALL without PV_SAMPLER_OVR_EN tie ovr to 0 and contain no overrange logic.

Structure
REQ-033 SHALL place ADC_W=12, PWR_W=24 and the FSM state encoding (one-hot, 5 states) in shared package pso_pkg.
REQ-034 SHALL implement ADC clock generation and fall-edge strobe in sub-module pvs_adc_clkgen (enable in; adc_clk, sample_stb out).

Verification (ADC_DIV=2, AVG_LOG2=2, SETTLE_CYC=4)
REQ-035 SHALL verify: ad1_in=2000, ad2_in=1000 constant, start pulse -> done at cycle 22, v_avg=2000, i_avg=1000, power=2000000, ovr=0.
REQ-036 SHALL verify: ad1_in sequence 100,200,300,403 per sample, ad2_in=10 -> v_avg=250 (truncated), power=2500.
REQ-037 SHALL verify: ad1_in=4095, ad2_in=4095 -> power=16769025; ovr=1 with PV_SAMPLER_OVR_EN, 0 without.
REQ-038 SHALL verify: reset asserted at cycle 10 of SAMPLE -> next cycle IDLE, ADC clocks low, all outputs 0, no done.
REQ-039 SHALL verify: start held high continuously -> back-to-back measurements, done every 23 cycles, busy low exactly one cycle between.
REQ-040 SHALL verify: ad1_clk period 4 cycles, exactly 4 rising edges per measurement, ad1_clk==ad2_clk always.

Source files
------------

// File: rtl/pso_pkg.sv
// pso_pkg: shared widths, FSM encoding and the power helper for pv_power_sampler.
//   ADC_W       : ADC code width (12)
//   PWR_W       : power product width (24)
//   pso_state_e : one-hot encoding of the five sampler states
//   pso_power() : full-width unsigned product of two ADC codes
package pso_pkg;

  localparam int ADC_W = 12;
  localparam int PWR_W = 24;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_SETTLE = 5'b00010,
    ST_SAMPLE = 5'b00100,
    ST_CALC   = 5'b01000,
    ST_DONE   = 5'b10000
  } pso_state_e;

  function automatic logic [PWR_W-1:0] pso_power(input logic [ADC_W-1:0] v_code,
                                                 input logic [ADC_W-1:0] i_code);
    return PWR_W'(v_code) * PWR_W'(i_code);
  endfunction

endpackage

// File: rtl/pvs_adc_clkgen.sv
// pvs_adc_clkgen: conversion clock for the two PV ADCs plus a one-cycle strobe
// marking the clk cycle at whose end the conversion clock falls.
// Parameters:
//   ADC_DIV    : clk cycles per conversion-clock half-period (>=1)
// Ports:
//   clk        : in  system clock
//   reset      : in  synchronous, active-high
//   enable     : in  run the conversion clock; low forces it low and rearms the divider
//   adc_clk    : out conversion clock, starts low after enable rises
//   sample_stb : out high in the last cycle of each high phase (data valid on the fall)
module pvs_adc_clkgen #(
  parameter int ADC_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic adc_clk,
  output logic sample_stb
);

  localparam int CNT_W = $clog2(ADC_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADC_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Down-counter reloads on terminal count; each terminal count flips the clock.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= CNT_LOAD;
      adc_clk <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= CNT_LOAD;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // Terminal count while high means the clock goes low at the next edge,
  // which is when the ADC outputs are taken.
  assign sample_stb = enable && adc_clk && (div_cnt == '0);

endmodule

// File: rtl/pv_power_sampler.sv
// pv_power_sampler: one-shot PV power measurement. After a start request it waits
// for the PWM duty to settle, clocks both ADCs for 2^AVG_LOG2 conversions, averages
// each channel and reports v_avg * i_avg as a tracking fitness value.
// Parameters:
//   ADC_DIV    : clk cycles per ADC clock half-period (>=1)
//   AVG_LOG2   : log2 of samples averaged per measurement (0..6)
//   SETTLE_CYC : clk cycles waited after start before sampling (>=1)
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   start            : measurement request, honoured in IDLE only
//   ad1_in, ad2_in   : voltage / current ADC codes (unsigned 12 bit)
//   ad1_clk, ad2_clk : ADC conversion clocks (identical)
//   busy             : high outside IDLE
//   done             : one-cycle pulse when results update
//   v_avg, i_avg     : averaged codes
//   power            : v_avg * i_avg (24 bit)
//   ovr              : a sample hit full scale during the last measurement
// Build option:
//   PV_SAMPLER_OVR_EN : when defined, ovr tracks full-scale samples; otherwise ovr is tied 0.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | SETTLE_CYC cycles for the PWM duty to settle, ADC clocks low
// SAMPLE | ADC clocks running, one sample accumulated per fall
// CALC   | averages and product registered
// DONE   | done pulse, results visible
module pv_power_sampler
  import pso_pkg::*;
#(
  parameter int ADC_DIV    = 4,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADC_W-1:0] ad1_in,
  input  logic [ADC_W-1:0] ad2_in,
  output logic             ad1_clk,
  output logic             ad2_clk,
  output logic             busy,
  output logic             done,
  output logic [ADC_W-1:0] v_avg,
  output logic [ADC_W-1:0] i_avg,
  output logic [PWR_W-1:0] power,
  output logic             ovr
);

  localparam int ACC_W   = ADC_W + AVG_LOG2;
  localparam int STL_W   = $clog2(SETTLE_CYC + 1);
  localparam int SCNT_W  = AVG_LOG2 + 1;
  localparam logic [STL_W-1:0]  STL_LOAD  = STL_W'(SETTLE_CYC - 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'((1 << AVG_LOG2) - 1);

  pso_state_e state, state_next;

  logic [STL_W-1:0]  settle_cnt;
  logic [SCNT_W-1:0] samp_cnt;
  logic [ACC_W-1:0]  vacc;
  logic [ACC_W-1:0]  iacc;
  logic              adc_en;
  logic              adc_clk;
  logic              sample_stb;
  logic [ADC_W-1:0]  v_calc;
  logic [ADC_W-1:0]  i_calc;

  pvs_adc_clkgen #(
    .ADC_DIV (ADC_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .enable     (adc_en),
    .adc_clk    (adc_clk),
    .sample_stb (sample_stb)
  );

  assign ad1_clk = adc_clk;
  assign ad2_clk = adc_clk;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    adc_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        adc_en = 1'b1;
        // The last strobe coincides with the final fall, so SAMPLE ends on it.
        if (sample_stb && (samp_cnt == '0)) state_next = ST_CALC;
      end
      ST_CALC: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Truncating divide by 2^AVG_LOG2; the accumulator cannot exceed 12 bits after the shift.
  assign v_calc = vacc[AVG_LOG2 +: ADC_W];
  assign i_calc = iacc[AVG_LOG2 +: ADC_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
      samp_cnt   <= '0;
      vacc       <= '0;
      iacc       <= '0;
      v_avg      <= '0;
      i_avg      <= '0;
      power      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            settle_cnt <= STL_LOAD;
            samp_cnt   <= SCNT_LOAD;
            vacc       <= '0;
            iacc       <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          if (sample_stb) begin
            vacc <= vacc + ACC_W'(ad1_in);
            iacc <= iacc + ACC_W'(ad2_in);
            if (samp_cnt != '0) samp_cnt <= samp_cnt - 1'b1;
          end
        end
        ST_CALC: begin
          v_avg <= v_calc;
          i_avg <= i_calc;
          power <= pso_power(v_calc, i_calc);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PV_SAMPLER_OVR_EN
  logic ovr_seen;
  logic ovr_q;

  // Sticky full-scale detector for the running measurement, published in CALC.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_seen <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        ovr_seen <= 1'b0;
      end else if ((state == ST_SAMPLE) && sample_stb &&
                   ((ad1_in == {ADC_W{1'b1}}) || (ad2_in == {ADC_W{1'b1}}))) begin
        ovr_seen <= 1'b1;
      end
      if (state == ST_CALC) ovr_q <= ovr_seen;
    end
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_pv_power_sampler.sv
module tb_pv_power_sampler;

  localparam int ADC_DIV    = 2;
  localparam int AVG_LOG2   = 2;
  localparam int SETTLE_CYC = 4;
  localparam int LAT        = 22;
  localparam int PERIOD     = 23;
`ifdef PV_SAMPLER_OVR_EN
  localparam logic OVR_FS = 1'b1;
`else
  localparam logic OVR_FS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] ad1_in;
  logic [11:0] ad2_in;
  logic        ad1_clk;
  logic        ad2_clk;
  logic        busy;
  logic        done;
  logic [11:0] v_avg;
  logic [11:0] i_avg;
  logic [23:0] power;
  logic        ovr;

  pv_power_sampler #(
    .ADC_DIV    (ADC_DIV),
    .AVG_LOG2   (AVG_LOG2),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ad1_in  (ad1_in),
    .ad2_in  (ad2_in),
    .ad1_clk (ad1_clk),
    .ad2_clk (ad2_clk),
    .busy    (busy),
    .done    (done),
    .v_avg   (v_avg),
    .i_avg   (i_avg),
    .power   (power),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] v;
    logic [11:0] i;
    logic [23:0] p;
    logic        o;
    int          launch;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: ADC clock shape and done-triggered scoreboard compare.
  logic prev_adclk = 1'b0;
  int   rise_cnt   = 0;
  int   last_rise  = -1;

  always @(negedge clk) begin
    check("adc_clk_match", 32'(ad1_clk), 32'(ad2_clk));
    if (reset) begin
      rise_cnt  = 0;
      last_rise = -1;
    end else if (ad1_clk === 1'b1 && prev_adclk === 1'b0) begin
      rise_cnt++;
      if (last_rise >= 0) check("adc_period", 32'(cyc - last_rise), 32'd4);
      last_rise = cyc;
    end
    prev_adclk = ad1_clk;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("v_avg", 32'(v_avg), 32'(e.v));
        check("i_avg", 32'(i_avg), 32'(e.i));
        check("power", 32'(power), 32'(e.p));
        check("ovr", 32'(ovr), 32'(e.o));
        check("latency", 32'(cyc - e.launch), 32'(LAT));
        check("adc_rises", 32'(rise_cnt), 32'd4);
      end
      rise_cnt  = 0;
      last_rise = -1;
    end
  end

  task automatic launch(input logic [11:0] v, input logic [11:0] i,
                        input logic [23:0] p, input logic o);
    exp_t e;
    check("launch_idle", 32'(busy), 32'd0);
    e.v = v; e.i = i; e.p = p; e.o = o; e.launch = cyc;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  logic [11:0] seq_v [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    int low_cnt;
    int l0;
    logic pclk;

    reset = 1'b1; start = 1'b0; ad1_in = '0; ad2_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_adclk", 32'(ad1_clk), 32'd0);
    check("rst_v",     32'(v_avg),   32'd0);
    check("rst_i",     32'(i_avg),   32'd0);
    check("rst_p",     32'(power),   32'd0);
    check("rst_ovr",   32'(ovr),     32'd0);

    // Constant inputs; start pulsed during the DONE cycle must be ignored.
    ad1_in = 12'd2000; ad2_in = 12'd1000;
    launch(12'd2000, 12'd1000, 24'd2000000, 1'b0);
    check("settle_busy", 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("stay_idle", 32'(busy), 32'd0);
    end
    exp_q.delete();

    // Per-sample voltage sequence, truncating average: 1003/4 = 250.
    seq_v[0] = 12'd100; seq_v[1] = 12'd200; seq_v[2] = 12'd300; seq_v[3] = 12'd403;
    ad1_in = seq_v[0]; ad2_in = 12'd10;
    launch(12'd250, 12'd10, 24'd2500, 1'b0);
    idx = 0; pclk = ad1_clk; n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (pclk === 1'b1 && ad1_clk === 1'b0 && idx < 3) begin
        idx++;
        ad1_in = seq_v[idx];
      end
      pclk = ad1_clk;
    end
    drain(5);

    // Full scale on both channels.
    ad1_in = 12'd4095; ad2_in = 12'd4095;
    launch(12'd4095, 12'd4095, 24'd16769025, OVR_FS);
    drain(60);

    // One below full scale: overrange must clear.
    ad1_in = 12'd4094; ad2_in = 12'd1;
    launch(12'd4094, 12'd1, 24'd4094, 1'b0);
    drain(60);

    // Reset at SAMPLE cycle 10 (launch + 5 + 10): measurement discarded.
    ad1_in = 12'd500; ad2_in = 12'd600;
    l0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (cyc < l0 + 15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  32'(busy),    32'd0);
    check("mid_rst_done",  32'(done),    32'd0);
    check("mid_rst_ad1",   32'(ad1_clk), 32'd0);
    check("mid_rst_ad2",   32'(ad2_clk), 32'd0);
    check("mid_rst_v",     32'(v_avg),   32'd0);
    check("mid_rst_i",     32'(i_avg),   32'd0);
    check("mid_rst_p",     32'(power),   32'd0);
    check("mid_rst_ovr",   32'(ovr),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // Start held high: three back-to-back measurements, 23 cycles apart.
    ad1_in = 12'd1234; ad2_in = 12'd321;
    l0 = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.v = 12'd1234; e.i = 12'd321; e.p = 24'd396114; e.o = 1'b0;
      e.launch = l0 + k * PERIOD;
      exp_q.push_back(e);
    end
    start = 1'b1;
    low_cnt = 0;
    for (int k = 1; k <= 2 * PERIOD + LAT; k++) begin
      @(negedge clk);
      if (busy === 1'b0) low_cnt++;
    end
    start = 1'b0;
    check("b2b_busy_low", 32'(low_cnt), 32'd2);
    drain(10);
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
